// File: rtl/param_rom_stream_ctrl.sv
// Streams one parameter tensor per pass out of a fixed-latency, never-stalled ROM as a valid/ready stream.
// Define PARAM_STREAM_LAST_EN to add data_out_last, which flags the final beat of each pass.
module param_rom_stream_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int PARALLELISM = 1,
  parameter int OUT_DEPTH   = 32,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              restart,
  output logic [ADDR_WIDTH-1:0]             rom_addr,
  output logic                              rom_ce,
  input  logic [DATA_WIDTH*PARALLELISM-1:0] rom_q,
  output logic [DATA_WIDTH-1:0]             data_out [PARALLELISM],
  output logic                              data_out_valid,
  input  logic                              data_out_ready
`ifdef PARAM_STREAM_LAST_EN
  ,
  output logic                              data_out_last
`endif
);

  localparam int WORD_W = DATA_WIDTH * PARALLELISM;
`ifdef PARAM_STREAM_LAST_EN
  localparam int ENTRY_W = WORD_W + 1;
`else
  localparam int ENTRY_W = WORD_W;
`endif
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  generate
    if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_depth_check
      $error("param_rom_stream_ctrl: FIFO_DEPTH must be at least ROM_LATENCY+1");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ROM_LATENCY-1:0] tag_vld_q, tag_vld_d;
`ifdef PARAM_STREAM_LAST_EN
  logic [ROM_LATENCY-1:0] tag_last_q, tag_last_d;
`endif
  logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ENTRY_W-1:0]     head_q, head_d;
  logic [ENTRY_W-1:0]     push_entry;
  logic                   issue, push, pop;
  int                     inflight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rom_addr       = addr_q;
  assign rom_ce         = !rst;
  assign data_out_valid = (count_q != '0);

`ifdef PARAM_STREAM_LAST_EN
  assign push_entry    = {tag_last_q[ROM_LATENCY-1], rom_q};
  assign data_out_last = head_q[ENTRY_W-1];
`else
  assign push_entry    = rom_q;
`endif

  // Credit: FIFO occupancy plus reads still inside the ROM must never exceed FIFO_DEPTH.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < ROM_LATENCY; i++) inflight += int'(tag_vld_q[i]);
    issue = !rst && !restart && (int'(count_q) + inflight < FIFO_DEPTH);

    addr_d = addr_q;
    if (restart) addr_d = '0;
    else if (issue) addr_d = (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

    tag_vld_d = '0;
`ifdef PARAM_STREAM_LAST_EN
    tag_last_d = '0;
`endif
    if (!restart) begin
      tag_vld_d[0] = issue;
      for (int i = 1; i < ROM_LATENCY; i++) tag_vld_d[i] = tag_vld_q[i-1];
`ifdef PARAM_STREAM_LAST_EN
      tag_last_d[0] = (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1));
      for (int i = 1; i < ROM_LATENCY; i++) tag_last_d[i] = tag_last_q[i-1];
`endif
    end
  end

  always_comb begin
    push = tag_vld_q[ROM_LATENCY-1] && !restart;
    pop  = data_out_valid && data_out_ready && !restart;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (restart) count_d = '0;

    wr_ptr_d = restart ? '0 : (push ? ptr_inc(wr_ptr_q) : wr_ptr_q);
    rd_ptr_d = restart ? '0 : (pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q);

    // Head register: holds its value whenever the FIFO ends up empty, so data_out is never zeroed.
    head_d = head_q;
    if (!restart && count_d != '0) begin
      if (count_q == '0 || (pop && count_q == CNT_W'(1))) head_d = push_entry;
      else if (pop) head_d = mem[ptr_inc(rd_ptr_q)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      tag_vld_q  <= '0;
`ifdef PARAM_STREAM_LAST_EN
      tag_last_q <= '0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      tag_vld_q  <= tag_vld_d;
`ifdef PARAM_STREAM_LAST_EN
      tag_last_q <= tag_last_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= push_entry;
  end

  genvar gi;
  generate
    for (gi = 0; gi < PARALLELISM; gi++) begin : g_lane
      assign data_out[gi] = head_q[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Randomised-ready bench for param_rom_stream_ctrl; the expected stream is simply beat index mod OUT_DEPTH.
`timescale 1ns/1ps
module tb_param_rom_stream_ctrl;
  localparam int DW = 16;
  localparam int P  = 1;
  localparam int OD = 32;
  localparam int RL = 2;
  localparam int FD = 4;
  localparam int AW = $clog2(OD + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            restart = 1'b0;
  logic [AW-1:0]   rom_addr;
  logic            rom_ce;
  logic [DW*P-1:0] rom_q = '0;
  logic [DW*P-1:0] rom_p1 = '0;
  logic [DW-1:0]   data_out [P];
  logic            data_out_valid;
  logic            data_out_ready = 1'b0;
`ifdef PARAM_STREAM_LAST_EN
  logic            data_out_last;
`endif

  param_rom_stream_ctrl #(
    .DATA_WIDTH(DW), .PARALLELISM(P), .OUT_DEPTH(OD), .ROM_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_q(rom_q),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
`ifdef PARAM_STREAM_LAST_EN
    , .data_out_last(data_out_last)
`endif
  );

  always #5 clk = ~clk;

  // Two-edge ROM holding ROM[i] = i.
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_p1 <= (DW*P)'(rom_addr);
      rom_q  <= rom_p1;
    end
  end

  int            n_checks = 0;
  int            n_errors = 0;
  int            exp_beat = 0;
  int            issued   = 0;
  int            accepted = 0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start of a fresh pass (after reset release or restart): expect beat 0 next.
  task automatic resync();
    issued    = 0;
    accepted  = 0;
    exp_beat  = 0;
    prev_addr = rom_addr;
    prev_hold = 1'b0;
  endtask

  // Called at a negedge after ready for this cycle is set; the handshake completes at the next posedge.
  task automatic observe();
    if (rom_addr != prev_addr) issued++;
    prev_addr = rom_addr;
    check("credit", longint'(issued - accepted <= FD), 1);
    if (prev_hold) begin
      check("hold_valid", data_out_valid, 1);
      check("hold_data", data_out[0], prev_data);
    end
    if (data_out_valid && data_out_ready) begin
      check("beat", data_out[0], exp_beat % OD);
`ifdef PARAM_STREAM_LAST_EN
      check("last", data_out_last, longint'((exp_beat % OD) == OD - 1));
`endif
      $display("beat %0d data=%0d", exp_beat, data_out[0]);
      exp_beat++;
      accepted++;
    end
    prev_hold = data_out_valid && !data_out_ready;
    prev_data = data_out[0];
  endtask

  task automatic step(input logic rdy);
    @(negedge clk);
    data_out_ready = rdy;
    observe();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int guard;

    // Reset state and latency with ready held high.
    repeat (3) @(negedge clk);
    check("rst_addr", rom_addr, 0);
    check("rst_ce", rom_ce, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_data", data_out[0], 0);
    rst = 1'b0;
    data_out_ready = 1'b1;
    resync();
    step(1'b1); check("lat_c1", data_out_valid, 0);
    step(1'b1); check("lat_c2", data_out_valid, 0);
    step(1'b1); check("lat_c3", data_out_valid, 1);
    for (int i = 0; i < 99; i++) begin
      step(1'b1);
      check("no_bubble", data_out_valid, 1);
    end
    check("stream_cnt", exp_beat, 100);

    // Reset mid-stream, then backpressure from the first cycle.
    @(negedge clk);
    rst = 1'b1;
    data_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_ce", rom_ce, 0);
      check("mid_rst_valid", data_out_valid, 0);
      check("mid_rst_data", data_out[0], 0);
      check("mid_rst_addr", rom_addr, 0);
    end
    rst = 1'b0;
    resync();
    step(1'b0); check("bp_c1", data_out_valid, 0);
    step(1'b0); check("bp_c2", data_out_valid, 0);
    step(1'b0); check("bp_c3_valid", data_out_valid, 1);
    check("bp_c3_data", data_out[0], 0);
    repeat (17) step(1'b0);
    check("bp_addr_hold", rom_addr, 4);
    check("bp_issued", issued, 4);
    check("bp_valid", data_out_valid, 1);
    check("bp_data", data_out[0], 0);
    repeat (40) step(1'b1);
    check("bp_drain_cnt", exp_beat, 40);

    // Random ready at 50%.
    start = exp_beat;
    guard = 0;
    while (exp_beat - start < 500 && guard < 5000) begin
      step($urandom_range(0, 1) == 1);
      guard++;
    end
    check("rand_beats", exp_beat - start, 500);

    // Restart with the FIFO full after beat value 10 was taken.
    guard = 0;
    while ((exp_beat % OD) != 11 && guard < 200) begin
      step(1'b1);
      guard++;
    end
    check("pre_restart_pos", exp_beat % OD, 11);
    repeat (8) step(1'b0);
    check("full_valid", data_out_valid, 1);
    check("full_issued", issued - accepted, FD);
    @(negedge clk);
    restart = 1'b1;
    data_out_ready = 1'b0;
    observe();
    @(negedge clk);
    restart = 1'b0;
    check("restart_valid", data_out_valid, 0);
    check("restart_addr", rom_addr, 0);
    resync();
    step(1'b1); check("rs_c1", data_out_valid, 0);
    step(1'b1); check("rs_c2", data_out_valid, 0);
    step(1'b1); check("rs_c3", data_out_valid, 1);
    start = exp_beat;
    guard = 0;
    while (exp_beat - start < 80 && guard < 2000) begin
      step($urandom_range(0, 1) == 1);
      guard++;
    end
    check("rs_beats", exp_beat - start, 80);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
